vga_image_ctrl: RTL
===================

Name: vga_image_ctrl

Overview:
- Parametrised VGA timing generator and image-window controller; successor to the fixed 800x600 single-image display controller.
- Generates hsync, vsync and data-enable from configurable timing.
- Places an IMG_W x IMG_H image stored in an external synchronous ROM at a runtime-programmable position, with optional 2x pixel replication and a programmable background colour.
- Sits between the pixel-clock domain image ROM and the VGA DAC/pins.

Parameters:
H_SYNC, 128, hsync pulse width (pixels)
H_BP, 88, horizontal back porch
H_ACT, 800, horizontal active pixels
H_FP, 40, horizontal front porch
V_SYNC, 4, vsync width (lines)
V_BP, 23, vertical back porch
V_ACT, 600, vertical active lines
V_FP, 1, vertical front porch
SYNC_POL, 0, sync active level (0 = active-low)
IMG_W, 220, image width (pixels)
IMG_H, 180, image height (lines)
RGB_W, 8, colour width (3:3:2 default)
ROM_LAT, 1, ROM read latency in clocks (>=1)
ADDR_W, 16, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset
rom_data  in  RGB_W  ROM read data, valid ROM_LAT clocks after rom_addr
img_x  in  12  image left edge, relative to first active pixel
img_y  in  12  image top edge, relative to first active line
scale_2x  in  1  1 = each image pixel shown as 2x2
bg_rgb  in  RGB_W  colour for active pixels outside the image
rom_addr  out  ADDR_W  ROM read address (registered)
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_de  out  1  active-video flag
vga_rgb  out  RGB_W  pixel colour
frame_start  out  1  one-clock pulse at h=0, v=0 (undelayed counter domain)

Behaviour:
- Reset is asynchronous, active-low (rst_n); all state is clocked on clk rising edge.
- Reset values:
  - counters 0, rom_addr 0, vga_rgb 0, vga_de 0, frame_start 0.
  - vga_hs and vga_vs at their inactive level (!SYNC_POL).
  - All pipeline stages are cleared.
- Counters:
  - h counts 0..H_TOT-1, where H_TOT = sum of the four H parameters; wraps to 0.
  - v increments only when h = H_TOT-1; it wraps to 0 when h = H_TOT-1 and v = V_TOT-1.
  - Defaults give 1056 x 628.
- Region ordering from counter origin:
  - Horizontal: sync [0, H_SYNC-1], then back porch, then active [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT-1], then front porch.
  - Vertical uses the same ordering.
- Raw flags (function of h, v):
  - hs_raw = h < H_SYNC.
  - vs_raw = v < V_SYNC; the vsync edge is aligned to h = 0.
  - de_raw = h and v both in their active regions.
- Position shadowing:
  - img_x, img_y and scale_2x are sampled into shadow registers only on the frame_start cycle.
  - Mid-frame changes take effect on the next frame; there is no tearing.
- Image window, with ax/ay the active-relative coordinates:
  - in_img = de_raw && ax in [sx, sx+S*IMG_W-1] && ay in [sy, sy+S*IMG_H-1], where S = 2 if the shadowed scale is set, else 1.
  - A window exceeding the active area is clipped: off-screen pixels are never shown.
  - The address still advances so that visible pixels are correct.
- Address generation (incremental, no multiplier):
  - row_base resets to 0 at frame start.
  - col resets at the start of each image row.
  - rom_addr = row_base + col/S.
  - At the end of each image line, row_base += IMG_W; in 2x mode this happens only after every second line.
  - Addresses outside the window are don't-care but stable (hold the last value).
  - rom_addr never exceeds IMG_W*IMG_H-1.
  - The address is recomputed every frame; there is no free-running wrap counter.
- Latency:
  - Every output for pixel (h, v) appears PIPE = ROM_LAT+2 clocks after the counters hold (h, v).
  - hs, vs, de and in_img are delayed through matching shift registers so sync, de and rgb stay mutually aligned.
- vga_rgb:
  - rom_data when the delayed in_img = 1.
  - Otherwise bg_rgb when the delayed de = 1.
  - Otherwise 0.
  - Never non-zero during blanking.
- vga_hs = SYNC_POL ? hs_d : !hs_d; vga_vs likewise.
- Reset mid-frame: all outputs return to reset values asynchronously; after release, operation restarts at h = 0, v = 0 with a frame_start pulse on the first clock.

Decomposition:
- Shared package vga_pkg holds:
  - timing localparams H_TOT and V_TOT, active start/end constants;
  - the RGB_W default;
  - the 3:3:2 colour constants (black, bg defaults).
- One natural sub-module, vga_timing_gen: h/v counters, raw hs/vs/de, active-relative ax/ay, frame_start. It is reusable by other display blocks.
- The image-window/address logic and the delay pipeline stay in vga_image_ctrl.

Test Plan:
- Reset, then run two frames at defaults:
  - hs low for exactly 128 clocks every 1056;
  - vs low for exactly 4 lines (4224 clocks) every 628 lines;
  - frame_start period 663168 clocks.
- img_x = 0, img_y = 0, scale 1, ROM returns its address LSBs:
  - first non-bg rgb on the first active pixel;
  - de high 800 clocks per line;
  - rom_addr runs 0..219 on line 0 and reaches 39599 on the last image pixel;
  - next frame restarts at 0.
- Pipeline alignment, ROM_LAT = 1 and ROM_LAT = 3:
  - the de rising edge coincides with the first image pixel;
  - the offset from the hs falling edge to the de rise equals 216 clocks for both latencies.
- Change img_x from 100 to 300 mid-frame:
  - the current frame keeps its image at ax = 100;
  - the next frame places it at ax = 300;
  - bg_rgb fills the remaining active area, and rgb is 0 in blanking.
- scale_2x = 1:
  - each address is held for 2 clocks and each row base repeats for 2 lines;
  - the window is 440x360;
  - the last address is 39599.
- Clipping with img_x = 700:
  - only 100 image pixels are shown per line;
  - the row_base step is still 220, so the second line starts at address 220;
  - no rgb appears outside de.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals and 3:3:2 colour constants.
package vga_pkg;

  localparam int unsigned DEF_H_SYNC = 128;
  localparam int unsigned DEF_H_BP   = 88;
  localparam int unsigned DEF_H_ACT  = 800;
  localparam int unsigned DEF_H_FP   = 40;
  localparam int unsigned DEF_V_SYNC = 4;
  localparam int unsigned DEF_V_BP   = 23;
  localparam int unsigned DEF_V_ACT  = 600;
  localparam int unsigned DEF_V_FP   = 1;

  localparam int unsigned H_TOT = DEF_H_SYNC + DEF_H_BP + DEF_H_ACT + DEF_H_FP;
  localparam int unsigned V_TOT = DEF_V_SYNC + DEF_V_BP + DEF_V_ACT + DEF_V_FP;

  localparam int unsigned H_ACT_START = DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned H_ACT_END   = H_ACT_START + DEF_H_ACT - 1;
  localparam int unsigned V_ACT_START = DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned V_ACT_END   = V_ACT_START + DEF_V_ACT - 1;

  localparam int unsigned DEF_RGB_W = 8;

  // 3:3:2 colours: R[7:5] G[4:2] B[1:0]
  localparam logic [7:0] RGB_BLACK  = 8'h00;
  localparam logic [7:0] RGB_WHITE  = 8'hff;
  localparam logic [7:0] RGB_BG_DEF = 8'h02;

endpackage

// File: rtl/vga_image_ctrl_if.sv
// ROM read port plus VGA pin bundle of the image controller.
interface vga_image_ctrl_if #(
  parameter int unsigned RGB_W  = 8,
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic [RGB_W-1:0]  rom_data;
  logic              vga_hs;
  logic              vga_vs;
  logic              vga_de;
  logic [RGB_W-1:0]  vga_rgb;

  modport master (
    output rom_addr, vga_hs, vga_vs, vga_de, vga_rgb,
    input  rom_data
  );

  modport slave (
    input  rom_addr, vga_hs, vga_vs, vga_de, vga_rgb,
    output rom_data
  );
endinterface

// File: rtl/vga_timing_gen.sv
// h/v raster counters with raw sync/active flags and active-relative coordinates.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC = DEF_H_SYNC,
  parameter int unsigned H_BP   = DEF_H_BP,
  parameter int unsigned H_ACT  = DEF_H_ACT,
  parameter int unsigned H_FP   = DEF_H_FP,
  parameter int unsigned V_SYNC = DEF_V_SYNC,
  parameter int unsigned V_BP   = DEF_V_BP,
  parameter int unsigned V_ACT  = DEF_V_ACT,
  parameter int unsigned V_FP   = DEF_V_FP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        hs_raw,
  output logic        vs_raw,
  output logic        de_raw,
  output logic        v_act,
  output logic        line_end,
  output logic        frame_start,
  output logic [11:0] ax,
  output logic [11:0] ay
);

  localparam int unsigned HTot = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned VTot = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [11:0] HLast    = 12'(HTot - 1);
  localparam logic [11:0] VLast    = 12'(VTot - 1);
  localparam logic [11:0] HSyncEnd = 12'(H_SYNC);
  localparam logic [11:0] VSyncEnd = 12'(V_SYNC);
  localparam logic [11:0] HStart   = 12'(H_SYNC + H_BP);
  localparam logic [11:0] HEnd     = 12'(H_SYNC + H_BP + H_ACT);
  localparam logic [11:0] VStart   = 12'(V_SYNC + V_BP);
  localparam logic [11:0] VEnd     = 12'(V_SYNC + V_BP + V_ACT);

  logic [11:0] h_q, h_d, v_q, v_d;
  logic        h_act;

  // Next raster position: h wraps every line, v steps on the last pixel of a line.
  always_comb begin
    h_d = h_q + 12'd1;
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 12'd1;
    end
  end

  // Raster counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign hs_raw   = h_q < HSyncEnd;
  assign vs_raw   = v_q < VSyncEnd;
  assign h_act    = (h_q >= HStart) && (h_q < HEnd);
  assign v_act    = (v_q >= VStart) && (v_q < VEnd);
  assign de_raw   = h_act && v_act;
  assign line_end = h_q == HLast;
  assign ax       = h_q - HStart;
  assign ay       = v_q - VStart;

  // Gated by reset so the pulse stays low while held in reset at the origin.
  assign frame_start = rst_n && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_image_ctrl.sv
// VGA timing plus a ROM-backed image window with per-frame position shadowing.
module vga_image_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACT    = DEF_H_ACT,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACT    = DEF_V_ACT,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned IMG_W    = 220,
  parameter int unsigned IMG_H    = 180,
  parameter int unsigned RGB_W    = DEF_RGB_W,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [11:0]           img_x,
  input  logic [11:0]           img_y,
  input  logic                  scale_2x,
  input  logic [RGB_W-1:0]      bg_rgb,
  output logic                  frame_start,
  vga_image_ctrl_if.master      bus
);

  // Address register (1) + ROM latency + output colour register (1).
  localparam int unsigned Pipe = ROM_LAT + 2;

  localparam logic [12:0]       SpanW1 = 13'(IMG_W);
  localparam logic [12:0]       SpanW2 = 13'(2 * IMG_W);
  localparam logic [12:0]       SpanH1 = 13'(IMG_H);
  localparam logic [12:0]       SpanH2 = 13'(2 * IMG_H);
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(IMG_W);

  logic        hs_raw, vs_raw, de_raw, v_act, line_end;
  logic [11:0] ax, ay;

  vga_timing_gen #(
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .H_ACT  (H_ACT),
    .H_FP   (H_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP),
    .V_ACT  (V_ACT),
    .V_FP   (V_FP)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .de_raw      (de_raw),
    .v_act       (v_act),
    .line_end    (line_end),
    .frame_start (frame_start),
    .ax          (ax),
    .ay          (ay)
  );

  logic [11:0]       sx_q, sy_q;
  logic              s2_q;
  logic [11:0]       rel_x, rel_y;
  logic              x_in, y_in, in_img;
  logic [ADDR_W-1:0] col_q, col_d, row_base_q, row_base_d, rom_addr_q, rom_addr_d;
  logic              rep_q, rep_d;
  logic [Pipe-1:0]   hs_sr, vs_sr, de_sr;
  logic [Pipe-2:0]   in_sr;
  logic [RGB_W-1:0]  rgb_q;

  // Position/scale shadows, only loaded at the frame origin so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q <= '0;
      sy_q <= '0;
      s2_q <= 1'b0;
    end else if (frame_start) begin
      sx_q <= img_x;
      sy_q <= img_y;
      s2_q <= scale_2x;
    end
  end

  assign rel_x  = ax - sx_q;
  assign rel_y  = ay - sy_q;
  assign x_in   = (ax >= sx_q) && ({1'b0, rel_x} < (s2_q ? SpanW2 : SpanW1));
  assign y_in   = (ay >= sy_q) && ({1'b0, rel_y} < (s2_q ? SpanH2 : SpanH1));
  assign in_img = de_raw && x_in && y_in;

  // Incremental address walk: col steps per visible image pixel, row_base per image row.
  always_comb begin
    col_d      = col_q;
    row_base_d = row_base_q;
    rep_d      = rep_q;
    rom_addr_d = rom_addr_q;
    if (in_img) begin
      rom_addr_d = row_base_q + (s2_q ? (col_q >> 1) : col_q);
    end
    if (frame_start) begin
      col_d      = '0;
      row_base_d = '0;
      rep_d      = 1'b0;
    end else if (line_end) begin
      col_d = '0;
      if (v_act && y_in) begin
        // In 2x mode each source row is shown twice; step only after the second.
        rep_d = s2_q && !rep_q;
        if (!s2_q || rep_q) begin
          row_base_d = row_base_q + RowStep;
        end
      end
    end else if (in_img) begin
      col_d = col_q + ADDR_W'(1);
    end
  end

  // Address generator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_base_q <= '0;
      rep_q      <= 1'b0;
      rom_addr_q <= '0;
    end else begin
      col_q      <= col_d;
      row_base_q <= row_base_d;
      rep_q      <= rep_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  // Flag delay lines and output colour mux, aligned to the ROM return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sr <= '0;
      vs_sr <= '0;
      de_sr <= '0;
      in_sr <= '0;
      rgb_q <= '0;
    end else begin
      hs_sr <= {hs_sr[Pipe-2:0], hs_raw};
      vs_sr <= {vs_sr[Pipe-2:0], vs_raw};
      de_sr <= {de_sr[Pipe-2:0], de_raw};
      in_sr <= {in_sr[Pipe-3:0], in_img};
      if (in_sr[Pipe-2]) begin
        rgb_q <= bus.rom_data;
      end else if (de_sr[Pipe-2]) begin
        rgb_q <= bg_rgb;
      end else begin
        rgb_q <= '0;
      end
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.vga_hs   = SYNC_POL ? hs_sr[Pipe-1] : !hs_sr[Pipe-1];
  assign bus.vga_vs   = SYNC_POL ? vs_sr[Pipe-1] : !vs_sr[Pipe-1];
  assign bus.vga_de   = de_sr[Pipe-1];
  assign bus.vga_rgb  = rgb_q;

endmodule
